// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: word-only data memory, RMW for SB/SH, load extension, fault decode.
// Optional LSU_PERF_CNT_EN adds load/store/fault response counters (tied to 0 otherwise).
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_load_data,
    output logic              resp_fault,
    output logic              mem_r_enable,
    output logic              mem_w_enable,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_re_data,
    output logic [31:0]       ld_count,
    output logic [31:0]       st_count,
    output logic [31:0]       fault_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_RESP
    } state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_lane;
    logic [2:0]  r_f3;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_load_data;
    logic        r_fault;
    logic [31:0] r_mem_addr;

    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_addr32;
    logic [31:0] w_merged;
    logic [31:0] w_ext;

    function automatic logic [31:0] f_extend(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   f_extend = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   f_extend = {{16{h[15] & ~f3[2]}}, h};
            default: f_extend = w;
        endcase
    endfunction

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_addr32 = 32'(req_addr);
    assign w_fault  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                   || (req_we && req_funct3[2])
                   || (req_addr >= ADDR_W'(MEM_WORDS * 4))
                   || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                   || ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    assign w_ext    = f_extend(mem_re_data, r_f3, r_lane);

    always_comb begin
        w_merged = r_merge;
        if (r_f3[1:0] == 2'b00)
            w_merged[8*r_lane +: 8] = r_wdata[7:0];
        else if (r_lane[1])
            w_merged[31:16] = r_wdata[15:0];
        else
            w_merged[15:0] = r_wdata[15:0];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (w_fault)                    w_next = S_RESP;
                else if (!req_we)               w_next = S_LOAD;
                else if (req_funct3 == 3'b010)  w_next = S_STORE;
                else                            w_next = S_RMW_RD;
            end
            S_LOAD:   w_next = S_RESP;
            S_STORE:  w_next = S_RESP;
            S_RMW_RD: w_next = S_RMW_WR;
            S_RMW_WR: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lane      <= '0;
            r_f3        <= '0;
            r_wdata     <= '0;
            r_merge     <= '0;
            r_load_data <= '0;
            r_fault     <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_lane  <= req_addr[1:0];
                r_f3    <= req_funct3;
                r_wdata <= req_wdata;
                r_fault <= w_fault;
                if (!w_fault)
                    r_mem_addr <= w_addr32 & 32'hFFFF_FFFC;
            end
            if (r_state == S_RMW_RD)
                r_merge <= mem_re_data;
            // Result only changes on entry to RESP, so it holds between responses.
            if ((w_next == S_RESP) && (r_state != S_RESP))
                r_load_data <= (r_state == S_LOAD) ? w_ext : 32'h0;
        end
    end

    assign req_ready      = (r_state == S_IDLE);
    assign resp_valid     = (r_state == S_RESP);
    assign resp_fault     = resp_valid && r_fault;
    assign resp_load_data = r_load_data;
    assign mem_r_enable   = (r_state == S_LOAD) || (r_state == S_RMW_RD);
    assign mem_w_enable   = (r_state == S_STORE) || (r_state == S_RMW_WR);
    assign mem_address    = r_mem_addr;
    assign mem_wr_data    = (r_state == S_STORE)  ? r_wdata :
                            (r_state == S_RMW_WR) ? w_merged : 32'h0;

`ifdef LSU_PERF_CNT_EN
    logic        r_we;
    logic [31:0] r_ld_cnt, r_st_cnt, r_fault_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_ld_cnt    <= '0;
            r_st_cnt    <= '0;
            r_fault_cnt <= '0;
        end else begin
            if (w_accept)
                r_we <= req_we;
            if (r_state == S_RESP) begin
                if (r_fault)   r_fault_cnt <= r_fault_cnt + 32'd1;
                else if (r_we) r_st_cnt    <= r_st_cnt + 32'd1;
                else           r_ld_cnt    <= r_ld_cnt + 32'd1;
            end
        end
    end

    assign ld_count    = r_ld_cnt;
    assign st_count    = r_st_cnt;
    assign fault_count = r_fault_cnt;
`else
    assign ld_count    = 32'h0;
    assign st_count    = 32'h0;
    assign fault_count = 32'h0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed table, hand sequences for back-to-back and reset-in-RMW,
// then random requests checked against a byte-array memory model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_fault, mem_r_enable, mem_w_enable;
    logic [31:0] resp_load_data, mem_address, mem_wr_data, mem_re_data;
    logic [31:0] ld_count, st_count, fault_count;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_WORDS(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_load_data(resp_load_data), .resp_fault(resp_fault),
        .mem_r_enable(mem_r_enable), .mem_w_enable(mem_w_enable), .mem_address(mem_address),
        .mem_wr_data(mem_wr_data), .mem_re_data(mem_re_data),
        .ld_count(ld_count), .st_count(st_count), .fault_count(fault_count)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h80F1_7F22 : 32'h1122_3344 + 32'(i) * 32'h0101_0101;
    endfunction

    // Word memory seen by the DUT
    logic [31:0] mem [32];
    logic        mem_init;
    assign mem_re_data = mem[mem_address[6:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else if (mem_w_enable) begin
            mem[mem_address[6:2]] <= mem_wr_data;
        end
    end

    // Reference model: byte-addressed memory and response counts
    logic [7:0] rb [128];
    int nvec = 0, nerr = 0;
    int m_ld = 0, m_st = 0, m_f = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_eval(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] d, output logic f,
                              output int lat, output logic [31:0] wr);
        int     n;
        longint v;
        logic [31:0] base;
        f = (f3 == 3) || (f3 >= 6) || (we && f3 >= 4) || (addr >= 128)
            || ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr % 4 != 0);
        n = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        d = 0; wr = 0; lat = 1;
        if (f) return;
        if (!we) begin
            lat = 2;
            v = 0;
            for (int k = 0; k < n; k++) v += longint'(rb[addr + k]) << (8 * k);
            if (f3 < 4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
            d = v[31:0];
        end else begin
            lat = (f3 == 2) ? 2 : 3;
            base = addr - addr % 4;
            for (int k = 0; k < 4; k++) begin
                if (base + k >= addr && base + k < addr + n)
                    wr[8*k +: 8] = wd[8*(base + k - addr) +: 8];
                else
                    wr[8*k +: 8] = rb[base + k];
            end
        end
    endtask

    task automatic model_commit(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd);
        logic [31:0] d, wr;
        logic        f;
        int          lat;
        model_eval(we, f3, addr, wd, d, f, lat, wr);
        if (f) m_f++;
        else if (!we) m_ld++;
        else begin
            m_st++;
            for (int k = 0; k < 4; k++) rb[addr - addr % 4 + k] = wr[8*k +: 8];
        end
    endtask

    // One request from an IDLE cycle to one cycle after its response; sampled on negedges.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_f,
                          input int exp_lat, input logic chk_wr, input logic [31:0] exp_wr);
        int   cyc;
        logic got, strobe;
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1; got = 1'b0; strobe = 1'b0;
        while (cyc <= 6 && !got) begin
            if (mem_r_enable || mem_w_enable) strobe = 1'b1;
            if (cyc == 1 && !exp_f) begin
                chk("cyc1_r_en", 32'(mem_r_enable), 32'(!we || f3 != 2));
                chk("cyc1_w_en", 32'(mem_w_enable), 32'(we && f3 == 2));
                chk("mem_address", mem_address, addr & 32'hFFFF_FFFC);
            end
            if (chk_wr && mem_w_enable) chk("mem_wr_data", mem_wr_data, exp_wr);
            if (resp_valid) got = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        chk("resp_latency", 32'(cyc), 32'(exp_lat));
        chk("resp_fault", 32'(resp_fault), 32'(exp_f));
        chk("resp_load_data", resp_load_data, exp_d);
        if (exp_f) chk("fault_no_strobe", 32'(strobe), 32'd0);
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("load_data_hold", resp_load_data, exp_d);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_load_data", resp_load_data, 32'd0);
        chk("rst_strobes", {30'd0, mem_r_enable, mem_w_enable}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wr_data", mem_wr_data, 32'd0);
        chk("rst_ld_count", ld_count, 32'd0);
        chk("rst_st_count", st_count, 32'd0);
        chk("rst_fault_count", fault_count, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_f;
        int          lat;
        logic        chk_wr;
        logic [31:0] exp_wr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] w, d, wr;
        logic        f, we;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        int          lat;

        tbl[0]  = '{1'b0, 3'b000, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 3'b100, 32'h13, 32'h0,         32'h0000_0080, 1'b0, 2, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 3'b001, 32'h12, 32'h0,         32'hFFFF_80F1, 1'b0, 2, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 3'b101, 32'h10, 32'h0,         32'h0000_7F22, 1'b0, 2, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 3'b000, 32'h11, 32'h1234_56AB, 32'h0,         1'b0, 3, 1'b1, 32'h80F1_AB22};
        tbl[5]  = '{1'b0, 3'b010, 32'h10, 32'h0,         32'h80F1_AB22, 1'b0, 2, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 3'b010, 32'h12, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 3'b001, 32'h11, 32'hFFFF_FFFF, 32'h0,         1'b1, 1, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 3'b000, 32'h80, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 3'b011, 32'h00, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 3'b100, 32'h20, 32'h55,        32'h0,         1'b1, 1, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 3'b010, 32'h7C, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1'b1, 32'hDEAD_BEEF};
        tbl[12] = '{1'b0, 3'b010, 32'h7C, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'h0};

        for (int i = 0; i < 32; i++) begin
            w = init_word(i);
            for (int k = 0; k < 4; k++) rb[4*i + k] = w[8*k +: 8];
        end

        rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].exp_d, tbl[i].exp_f,
                   tbl[i].lat, tbl[i].chk_wr, tbl[i].exp_wr);
            model_commit(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd);
        end

        // SW with req_valid held high into a following LW
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h7C;
        req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_we = 1'b0; req_wdata = 32'h0;
        chk("b2b_ready_store", 32'(req_ready), 32'd0);
        chk("b2b_w_en", 32'(mem_w_enable), 32'd1);
        @(negedge clk);
        chk("b2b_ready_resp", 32'(req_ready), 32'd0);
        chk("b2b_resp_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        chk("b2b_ready_idle", 32'(req_ready), 32'd1);
        chk("b2b_idle_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_load_r_en", 32'(mem_r_enable), 32'd1);
        @(negedge clk);
        chk("b2b_load_resp", 32'(resp_valid), 32'd1);
        chk("b2b_load_data", resp_load_data, 32'hCAFE_F00D);
        model_commit(1'b1, 3'b010, 32'h7C, 32'hCAFE_F00D);
        model_commit(1'b0, 3'b010, 32'h7C, 32'h0);
        @(negedge clk);

        // Reset during RMW_RD of SB 0x00 leaves word 0 untouched
        w = mem[0];
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0;
        req_wdata = 32'h0000_00EE;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_rd_r_en", 32'(mem_r_enable), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ld = 0; m_st = 0; m_f = 0;
        chk_reset_vals();
        repeat (3) @(negedge clk);
        chk("rst_word0_kept", mem[0], w);

        for (int i = 0; i < 200; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
            wd   = $urandom;
            model_eval(we, f3, addr, wd, d, f, lat, wr);
            do_req(we, f3, addr, wd, d, f, lat, we && !f, wr);
            model_commit(we, f3, addr, wd);
        end

`ifdef LSU_PERF_CNT_EN
        chk("ld_count", ld_count, 32'(m_ld));
        chk("st_count", st_count, 32'(m_st));
        chk("fault_count", fault_count, 32'(m_f));
`else
        chk("ld_count", ld_count, 32'd0);
        chk("st_count", st_count, 32'd0);
        chk("fault_count", fault_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
